// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg: shared types and helpers for the dmem_responder slice  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [7:0] strobe(input size_e size, input logic [2:0] lane);
        logic [7:0] s;
        case (size)
            SZ_B:    s = 8'h01;
            SZ_H:    s = 8'h03;
            SZ_W:    s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s << lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_mem_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lane_align: store strobe/data placement, load extract/extend |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic        [1:0]  size,
    input  logic        [2:0]  lane,
    input  logic               is_unsigned,
    input  logic        [63:0] wdata,
    input  logic        [63:0] rword,
    output logic        [7:0]  wstrb,
    output logic        [63:0] wdata_sh,
    output logic        [63:0] rdata
);

    logic [63:0] w_rsh;

    always_comb begin
        wstrb    = strobe(size_e'(size), lane);
        wdata_sh = wdata << {lane, 3'b000};
        w_rsh    = rword >> {lane, 3'b000};
        case (size_e'(size))
            SZ_B:    rdata = is_unsigned ? {56'd0, w_rsh[7:0]}  : {{56{w_rsh[7]}},  w_rsh[7:0]};
            SZ_H:    rdata = is_unsigned ? {48'd0, w_rsh[15:0]} : {{48{w_rsh[15]}}, w_rsh[15:0]};
            SZ_W:    rdata = is_unsigned ? {32'd0, w_rsh[31:0]} : {{32{w_rsh[31]}}, w_rsh[31:0]};
            default: rdata = w_rsh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder: single-outstanding data memory with latency      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_wen;
    logic        r_uns;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [1:0]  r_size;
    logic [63:0] mem [DEPTH];

    logic [63:0]      w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_mis;
    logic             w_oor;
    logic             w_err;
    logic             w_commit;
    logic [7:0]       w_strb;
    logic [63:0]      w_wdata_sh;
    logic [63:0]      w_rdata_ext;

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);

    // Word offset is kept at full width so the range check sees every upper bit.
    assign w_word = (r_addr - BASE) >> 3;
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_oor  = (r_addr < BASE) || (w_word >= 64'(DEPTH));
    assign w_err  = w_mis || w_oor;

    always_comb begin
        case (size_e'(r_size))
            SZ_B:    w_mis = 1'b0;
            SZ_H:    w_mis = r_addr[0];
            SZ_W:    w_mis = |r_addr[1:0];
            default: w_mis = |r_addr[2:0];
        endcase
    end

    assign w_commit = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    mem_lane_align u_align (
        .size        (r_size),
        .lane        (r_addr[2:0]),
        .is_unsigned (r_uns),
        .wdata       (r_wdata),
        .rword       (mem[w_idx]),
        .wstrb       (w_strb),
        .wdata_sh    (w_wdata_sh),
        .rdata       (w_rdata_ext)
    );

    // Held off during reset so a store caught mid-flight is dropped.
    always_ff @(posedge clk) begin
        if (rst && w_commit && r_wen && !w_err) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            r_wen      <= 1'b0;
            r_uns      <= 1'b0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_size     <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wen   <= req_wen;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        resp_err   <= w_err;
                        resp_rdata <= (w_err || r_wen) ? 64'd0 : w_rdata_ext;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
